bbc_mem_sched: RTL
==================

# bbc_mem_sched

Slot scheduler for the single SDRAM port of the BBC core. It owns the SDRAM address, write-enable and write-data mux, which the top level currently builds combinationally. Each `mem_sync` slot is granted to one of three requesters: ROM loader, video fetch or CPU. Read data is returned to the slot owner, and loader writes are buffered in a small FIFO so download bytes are never lost between slots.

## Interface
Parameters:
- `LD_DEPTH`, 4 — loader FIFO entries; power of two, 2..16.
- `ROM_BASE`, 25'h080000 — first SDRAM address of the ROM region.

Ports:
- `clk_sys` in 1 — 32 MHz system clock.
- `reset` in 1 — asynchronous, active-high.
- `mem_sync` in 1 — one-cycle pulse marking the start of an SDRAM slot.
- `phi0` in 1 — 0 = video half-cycle, 1 = CPU half-cycle; sampled at `mem_sync`.
- `loader_active` in 1 — download in progress.
- `ld_wr` in 1 — loader byte strobe.
- `ld_addr` in 25 — loader byte address.
- `ld_data` in 8 — loader byte data.
- `ld_full` out 1 — FIFO full.
- `ld_empty` out 1 — FIFO empty.
- `ld_ovf` out 1 — sticky overflow; cleared only by `reset`.
- `vid_adr` in 25 — video fetch address.
- `vid_di` out 8 — video read data.
- `cpu_adr` in 25 — CPU address, already mapped to SDRAM space.
- `cpu_we` in 1 — CPU write request.
- `cpu_ok` in 1 — CPU write targets writable memory.
- `cpu_do` in 8 — CPU write data.
- `cpu_di` out 8 — CPU read data.
- `sd_adr` out 25 — SDRAM address.
- `sd_we` out 1 — SDRAM write enable.
- `sd_di` out 8 — SDRAM write data.
- `sd_do` in 8 — SDRAM read data, valid when the next `mem_sync` is high.
- `owner` out 2 — current slot owner: 0 IDLE, 1 LOAD, 2 VID, 3 CPU.

## Operation
- Reset values:
  - `sd_adr` = 0, `sd_we` = 0, `sd_di` = 0.
  - `cpu_di` = 0, `vid_di` = 0.
  - `owner` = IDLE.
  - `ld_full` = 0, `ld_empty` = 1, `ld_ovf` = 0.
  - FIFO flushed.
- Loader FIFO:
  - `ld_wr` pushes {`ld_addr`, `ld_data`}.
  - A push when full is dropped and sets `ld_ovf`.
  - A push and a pop in the same cycle leave the count unchanged, including when full. The pushed entry is accepted in that case.
  - Pointers wrap modulo `LD_DEPTH`; the count is `$clog2(LD_DEPTH)+1` bits.
- Grant decision, evaluated on each `mem_sync`, first match wins:
  1. FIFO not empty and `loader_active` → LOAD; pop one entry.
  2. `loader_active` and FIFO empty → IDLE.
  3. `phi0` = 0 → VID.
  4. Otherwise → CPU.
- Drive on the grant cycle, registered and held until the next `mem_sync`:
  - LOAD: `sd_adr` = entry address, `sd_we` = 1, `sd_di` = entry data.
  - VID: `sd_adr` = `vid_adr`, `sd_we` = 0.
  - CPU: `sd_adr` = `cpu_adr`, `sd_we` = `cpu_we & cpu_ok`, `sd_di` = `cpu_do`.
  - IDLE: `sd_we` = 0; `sd_adr` holds its previous value.
- Read return:
  - On the next `mem_sync`, `sd_do` is captured into `vid_di` if the previous owner was VID, or into `cpu_di` if it was CPU.
  - The non-owner output holds its value.
  - A CPU write slot does not update `cpu_di`.
- Falling `loader_active` with the FIFO not empty: remaining entries keep rule 1 priority only while `loader_active` is high. After it falls, leftovers are discarded on the next `mem_sync` and `ld_ovf` is set.

## Timing
- Grant latency: outputs change 1 cycle after the `mem_sync` edge and are stable for the whole slot.
- Read latency: exactly one slot. Data appears on `cpu_di`/`vid_di` 1 cycle after the following `mem_sync`.
- Loader throughput: one byte per slot. The FIFO absorbs `data_io` bursts of up to `LD_DEPTH` bytes between slots.
- `reset` asserted mid-slot:
  - Outputs go to reset values immediately, with `sd_we` = 0 asynchronously.
  - After release, the first grant occurs on the next `mem_sync`.

## Configuration
- `BBC_MEM_SCHED_ROMWP_EN`:
  - Defined: a CPU slot with `cpu_adr` >= `ROM_BASE` forces `sd_we` = 0 regardless of `cpu_ok`. Loader writes are unaffected.
  - Undefined: `sd_we` depends only on `cpu_we & cpu_ok`.

## Structure
- Package `bbc_mem_pkg`:
  - enum `owner_t` {IDLE, LOAD, VID, CPU}.
  - typedef `sdram_addr_t` (25 bits).
  - default `ROM_BASE` constant.
- Sub-module `bbc_ld_fifo`: synchronous FIFO of width 33, depth `LD_DEPTH`, with full/empty flags.
- The top-level scheduler holds the grant FSM, output registers and read-return capture.

## Test plan
- **Reset:** assert `reset` mid-slot with `sd_we` = 1 → `sd_we` = 0 at once; all outputs at reset values; `owner` = IDLE.
- **Loader burst:**
  - Stimulus: `loader_active` = 1; push 4 bytes (addr 0x80000..0x80003, data 0xA0..0xA3) in 4 consecutive cycles; slots every 32 cycles.
  - Response: 4 LOAD slots in order with matching `sd_adr`/`sd_di`; `ld_full` = 1 after the 4th push; `ld_ovf` stays 0.
- **Overflow:** push a 5th byte while full with no pop in the same cycle → byte dropped; `ld_ovf` = 1 and stays 1 until `reset`.
- **Alternation:**
  - Stimulus: `loader_active` = 0; `phi0` toggles each slot; `vid_adr` = 0x03000 returns `sd_do` = 0x55; `cpu_adr` = 0x01234 returns 0x66.
  - Response: `owner` alternates VID/CPU; `vid_di` = 0x55 and `cpu_di` = 0x66, each one slot later.
- **CPU write gating:**
  - CPU slot with `cpu_we` = 1, `cpu_ok` = 0 → `sd_we` = 0.
  - CPU slot with `cpu_ok` = 1 and `cpu_adr` = 0x90000 → `sd_we` = 1 without the macro, 0 with `BBC_MEM_SCHED_ROMWP_EN`.
- **Simultaneous push/pop when full:** `ld_wr` coincides with a LOAD pop → count stays 4; the new entry is delivered after the 3 older ones.

Source files
------------

// File: rtl/bbc_mem_sched_pkg.sv
// bbc_mem_pkg: shared types and constants for the BBC SDRAM slot scheduler.
package bbc_mem_pkg;

  // Slot owner; encoding is visible on the owner port (0 IDLE .. 3 CPU).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    VID  = 2'd2,
    CPU  = 2'd3
  } owner_t;

  typedef logic [24:0] sdram_addr_t;

  // First SDRAM address of the ROM image region.
  localparam sdram_addr_t ROM_BASE_DEFAULT = 25'h080000;

  // Loader FIFO entry: {address[24:0], data[7:0]}.
  localparam int unsigned LD_W = 33;

endpackage

// File: rtl/bbc_mem_sched_ld_fifo.sv
// bbc_ld_fifo: small synchronous FIFO buffering ROM-loader writes between slots.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is dropped and drop_o pulses. flush_i empties the FIFO.
module bbc_ld_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);
  assign drop_o  = push_i && !flush_i && full_o && !do_pop;

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/bbc_mem_sched.sv
// bbc_mem_sched: grants each SDRAM slot (mem_sync) to the ROM loader, video or
// CPU, registers the SDRAM address/we/data mux and returns read data to the
// previous slot owner. Optional macro BBC_MEM_SCHED_ROMWP_EN write-protects
// CPU accesses at or above ROM_BASE.
module bbc_mem_sched
  import bbc_mem_pkg::*;
#(
  parameter int unsigned LD_DEPTH = 4,
  parameter sdram_addr_t ROM_BASE = ROM_BASE_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        mem_sync,
  input  logic        phi0,
  input  logic        loader_active,
  input  logic        ld_wr,
  input  logic [24:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_full,
  output logic        ld_empty,
  output logic        ld_ovf,
  input  logic [24:0] vid_adr,
  output logic [7:0]  vid_di,
  input  logic [24:0] cpu_adr,
  input  logic        cpu_we,
  input  logic        cpu_ok,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  output logic [24:0] sd_adr,
  output logic        sd_we,
  output logic [7:0]  sd_di,
  input  logic [7:0]  sd_do,
  output logic [1:0]  owner
);

  owner_t      owner_q, owner_d;
  sdram_addr_t sd_adr_q, sd_adr_d;
  logic        sd_we_q, sd_we_d;
  logic [7:0]  sd_di_q, sd_di_d;
  logic        cpu_wr_q, cpu_wr_d;
  logic [7:0]  vid_di_q, cpu_di_q;
  logic        ovf_q;

  logic            fifo_pop, fifo_flush, fifo_full, fifo_empty, fifo_drop;
  logic [LD_W-1:0] fifo_rdata;
  logic            cpu_wp;

  bbc_ld_fifo #(
    .DEPTH (LD_DEPTH),
    .WIDTH (LD_W)
  ) u_ld_fifo (
    .clk     (clk_sys),
    .rst     (reset),
    .push_i  (ld_wr),
    .wdata_i ({ld_addr, ld_data}),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

`ifdef BBC_MEM_SCHED_ROMWP_EN
  assign cpu_wp = (cpu_adr >= ROM_BASE);
`else
  assign cpu_wp = 1'b0;
`endif

  // Grant decision and next slot drive, evaluated only on mem_sync.
  always_comb begin
    owner_d    = owner_q;
    sd_adr_d   = sd_adr_q;
    sd_we_d    = sd_we_q;
    sd_di_d    = sd_di_q;
    cpu_wr_d   = cpu_wr_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    if (mem_sync) begin
      if (loader_active && !fifo_empty) begin
        owner_d  = LOAD;
        fifo_pop = 1'b1;
        sd_adr_d = fifo_rdata[32:8];
        sd_we_d  = 1'b1;
        sd_di_d  = fifo_rdata[7:0];
      end else if (loader_active) begin
        owner_d = IDLE;
        sd_we_d = 1'b0;
      end else begin
        // Leftovers after the download ended are discarded here.
        fifo_flush = !fifo_empty;
        if (!phi0) begin
          owner_d  = VID;
          sd_adr_d = vid_adr;
          sd_we_d  = 1'b0;
        end else begin
          owner_d  = CPU;
          sd_adr_d = cpu_adr;
          sd_we_d  = cpu_we && cpu_ok && !cpu_wp;
          sd_di_d  = cpu_do;
          cpu_wr_d = cpu_we;
        end
      end
    end
  end

  // Slot state and SDRAM drive registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      owner_q  <= IDLE;
      sd_adr_q <= '0;
      sd_we_q  <= 1'b0;
      sd_di_q  <= '0;
      cpu_wr_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      sd_adr_q <= sd_adr_d;
      sd_we_q  <= sd_we_d;
      sd_di_q  <= sd_di_d;
      cpu_wr_q <= cpu_wr_d;
    end
  end

  // Read return: capture sd_do for the owner of the slot that just ended.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vid_di_q <= '0;
      cpu_di_q <= '0;
    end else if (mem_sync) begin
      if (owner_q == VID) vid_di_q <= sd_do;
      if (owner_q == CPU && !cpu_wr_q) cpu_di_q <= sd_do;
    end
  end

  // Sticky overflow: dropped push or discarded leftovers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else if (fifo_drop || fifo_flush) ovf_q <= 1'b1;
  end

  assign owner    = owner_q;
  assign sd_adr   = sd_adr_q;
  assign sd_we    = sd_we_q;
  assign sd_di    = sd_di_q;
  assign vid_di   = vid_di_q;
  assign cpu_di   = cpu_di_q;
  assign ld_full  = fifo_full;
  assign ld_empty = fifo_empty;
  assign ld_ovf   = ovf_q;

endmodule
